// File: rtl/record_packer_pkg.sv
// Shared types for the record packer: the input-side FSM states and the record format.
package record_packer_pkg;

   typedef enum logic {
      GET_X,
      GET_Y
   } record_packer_sections_e;

   // x is the signed first word of a pair, y the unsigned second word
   typedef struct packed {
      logic signed [31:0] x;
      logic        [31:0] y;
   } record_t;

   localparam int unsigned DEFAULT_DEPTH = 4;
   localparam int unsigned DEFAULT_CNT_W = 16;

endpackage

// File: rtl/record_packer_if.sv
// Word-input and record-output handshake bus of the record packer.
interface record_packer_if #(
   parameter int CNT_W = 16
);
   import record_packer_pkg::*;

   logic [31:0]      word_in;
   logic             word_in_sync;
   logic             word_in_notify;
   record_t          rec_out;
   logic             rec_out_sync;
   logic             rec_out_notify;
   logic [CNT_W-1:0] rec_count;

   modport master (
      output word_in,
      output word_in_sync,
      output rec_out_sync,
      input  word_in_notify,
      input  rec_out,
      input  rec_out_notify,
      input  rec_count
   );

   modport slave (
      input  word_in,
      input  word_in_sync,
      input  rec_out_sync,
      output word_in_notify,
      output rec_out,
      output rec_out_notify,
      output rec_count
   );

endinterface

// File: rtl/record_packer_fifo.sv
// Small circular record buffer; storage is left unreset, the head output reads zero when empty.
module record_fifo
   import record_packer_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  record_t                data_in,
   output record_t                data_out,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int PTR_W = $clog2(DEPTH);

   record_t          mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == (PTR_W+1)'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   // Pointers are exactly log2(DEPTH) wide so they wrap without extra logic
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= data_in;
   end

   assign data_out = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/record_packer.sv
// Packs pairs of 32-bit words into records and offers them to the consumer through a FIFO.
module record_packer
   import record_packer_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int CNT_W = DEFAULT_CNT_W
) (
   input logic             clk,
   input logic             rst,
   record_packer_if.slave  bus
);

   record_packer_sections_e state;
   record_packer_sections_e state_d;

   logic signed [31:0]     x_hold;
   logic [CNT_W-1:0]       rec_count;
   logic                   word_ready;
   logic                   in_xfer;
   logic                   out_xfer;
   logic                   push;
   record_t                new_rec;
   record_t                head_rec;
   logic [$clog2(DEPTH):0] fifo_count;
   logic                   fifo_full;
   logic                   fifo_empty;

   // An x word only fills the holding register, so GET_X never has to wait for FIFO space
   assign word_ready = (state == GET_X) || !fifo_full;
   assign in_xfer    = word_ready && bus.word_in_sync;
   assign out_xfer   = !fifo_empty && bus.rec_out_sync;
   assign new_rec    = '{x: x_hold, y: bus.word_in};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= GET_X;
         x_hold    <= '0;
         rec_count <= '0;
      end else begin
         state <= state_d;
         if ((state == GET_X) && in_xfer) x_hold <= bus.word_in;
         if (out_xfer) rec_count <= rec_count + 1'b1;
      end
   end

   always_comb begin
      state_d = state;
      push    = 1'b0;
      case (state)
         GET_X: begin
            if (in_xfer) state_d = GET_Y;
         end
         GET_Y: begin
            if (in_xfer) begin
               push    = 1'b1;
               state_d = GET_X;
            end
         end
         default: state_d = GET_X;
      endcase
   end

   record_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push),
      .pop     (out_xfer),
      .data_in (new_rec),
      .data_out(head_rec),
      .count   (fifo_count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign bus.word_in_notify = word_ready;
   assign bus.rec_out        = head_rec;
   assign bus.rec_out_notify = (fifo_count != '0);
   assign bus.rec_count      = rec_count;

endmodule

// File: tb/tb_record_packer.sv
// Scoreboard bench for record_packer: directed scenarios followed by random traffic.
module tb_record_packer;
   import record_packer_pkg::*;

   localparam int DEPTH = 4;
   localparam int CNT_W = 4;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   record_packer_if #(.CNT_W(CNT_W)) bus ();

   record_packer #(
      .DEPTH(DEPTH),
      .CNT_W(CNT_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int          checks = 0;
   int          errors = 0;
   logic [63:0] sb[$];
   bit          phaseY;
   logic [31:0] heldX;
   int          recTotal;
   bit          expReady;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic ws, input logic [31:0] w, input logic os);
      @(posedge clk);
      #1;
      bus.word_in_sync = ws;
      bus.word_in      = w;
      bus.rec_out_sync = os;
   endtask

   // Presents a word and returns on the negedge before the edge that accepts it
   task automatic sendWord(input logic [31:0] w);
      @(posedge clk);
      #1;
      bus.word_in      = w;
      bus.word_in_sync = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (bus.word_in_notify) return;
      end
      checks++;
      errors++;
      $display("[TB] FAIL sendWord timeout: word %0h never accepted, expected acceptance", w);
   endtask

   task automatic resetDut();
      @(posedge clk);
      #1;
      rst              = 1'b1;
      bus.word_in_sync = 1'b0;
      bus.rec_out_sync = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Reference model: pairs become records, buffer holds DEPTH of them, handoffs are counted
   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
         phaseY   = 1'b0;
         heldX    = '0;
         recTotal = 0;
         checkOutput("reset word_in_notify", 64'(bus.word_in_notify), 64'd1);
         checkOutput("reset rec_out_notify", 64'(bus.rec_out_notify), 64'd0);
         checkOutput("reset rec_out", 64'(bus.rec_out), 64'd0);
         checkOutput("reset rec_count", 64'(bus.rec_count), 64'd0);
      end else begin
         expReady = !phaseY || (sb.size() < DEPTH);
         checkOutput("word_in_notify", 64'(bus.word_in_notify), 64'(expReady));
         checkOutput("rec_out_notify", 64'(bus.rec_out_notify), 64'(sb.size() != 0));
         checkOutput("rec_out", 64'(bus.rec_out), (sb.size() != 0) ? sb[0] : 64'd0);
         checkOutput("rec_count", 64'(bus.rec_count), 64'(recTotal % (1 << CNT_W)));
         if (bus.rec_out_notify && bus.rec_out_sync) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected record: got %0h, expected none", bus.rec_out);
            end else begin
               void'(sb.pop_front());
            end
            recTotal++;
         end
         if (expReady && bus.word_in_sync) begin
            if (!phaseY) heldX = bus.word_in;
            else         sb.push_back({heldX, bus.word_in});
            phaseY = !phaseY;
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst              = 1'b1;
      bus.word_in      = '0;
      bus.word_in_sync = 1'b0;
      bus.rec_out_sync = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Idle after reset
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, $urandom, 1'b0);

      // First record: x=-5, y=7, consumed right away
      bus.rec_out_sync = 1'b1;
      sendWord(32'hFFFF_FFFB);
      sendWord(32'd7);
      @(posedge clk);
      #1 bus.word_in_sync = 1'b0;
      @(negedge clk);
      checkOutput("first record", 64'(bus.rec_out), {32'hFFFF_FFFB, 32'd7});
      checkOutput("first notify", 64'(bus.rec_out_notify), 64'd1);
      @(negedge clk);
      checkOutput("first rec_count", 64'(bus.rec_count), 64'd1);

      // Fill the FIFO with the consumer stalled, then release one slot
      bus.rec_out_sync = 1'b0;
      for (int i = 0; i < 9; i++) sendWord($urandom);
      fork
         sendWord($urandom);
         begin
            repeat (6) @(posedge clk);
            #1 bus.rec_out_sync = 1'b1;
            @(posedge clk);
            #1 bus.rec_out_sync = 1'b0;
         end
      join
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, $urandom, 1'b1);

      // Continuous stream from a fresh reset; rec_count wraps in CNT_W bits
      resetDut();
      bus.rec_out_sync = 1'b1;
      for (int i = 0; i < 40; i++) sendWord($urandom);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, $urandom, 1'b1);
      @(negedge clk);
      checkOutput("stream rec_count", 64'(bus.rec_count), 64'd4);

      // Asynchronous reset between an x and a y word with two records buffered
      bus.rec_out_sync = 1'b0;
      for (int i = 0; i < 5; i++) sendWord($urandom);
      @(posedge clk);
      #1 bus.word_in_sync = 1'b0;
      #2 rst = 1'b1;
      #1;
      checkOutput("async word_in_notify", 64'(bus.word_in_notify), 64'd1);
      checkOutput("async rec_out_notify", 64'(bus.rec_out_notify), 64'd0);
      checkOutput("async rec_out", 64'(bus.rec_out), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      sendWord(32'h1234_5678);
      sendWord(32'h9ABC_DEF0);
      @(posedge clk);
      #1 bus.word_in_sync = 1'b0;
      @(negedge clk);
      checkOutput("post-reset record", 64'(bus.rec_out), {32'h1234_5678, 32'h9ABC_DEF0});
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, $urandom, 1'b1);
      @(negedge clk);
      checkOutput("post-reset rec_count", 64'(bus.rec_count), 64'd1);
      checkOutput("post-reset drained", 64'(bus.rec_out_notify), 64'd0);

      // Random traffic on both sides
      for (int i = 0; i < 400; i++)
         applyStimulus(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, $urandom, 1'b1);
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
